// File: rtl/pcpi_initiator.sv
// PCPI initiator: takes one instruction plus operands on a valid/ready command port,
// presents it to the co-processors and returns the co-processor result (or a timeout)
// on a valid/ready response port.
module pcpi_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_insn_i,
    input  logic [31:0] cmd_rs1_i,
    input  logic [31:0] cmd_rs2_i,

    output logic        pcpi_valid_o,
    output logic [31:0] pcpi_insn_o,
    output logic [31:0] pcpi_rs1_o,
    output logic [31:0] pcpi_rs2_o,
    input  logic        pcpi_wr_i,
    input  logic [31:0] pcpi_rd_i,
    input  logic        pcpi_wait_i,
    input  logic        pcpi_ready_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_wr_o,
    output logic [31:0] rsp_rd_o,
    output logic        rsp_timeout_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
    // Counter value on the last unclaimed cycle before the request is abandoned.
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     insn_q, insn_d;
    logic [31:0]     rs1_q, rs1_d;
    logic [31:0]     rs2_q, rs2_d;
    logic            rsp_wr_q, rsp_wr_d;
    logic [31:0]     rsp_rd_q, rsp_rd_d;
    logic            rsp_to_q, rsp_to_d;

    logic            unclaimed_last;

    // Final unclaimed cycle: nobody answered and nobody is holding the request.
    assign unclaimed_last = !pcpi_ready_i && !pcpi_wait_i && (cnt_q >= CntLast);

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ready has priority over the timeout terminal count
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (cmd_valid_i) state_d = StBusy;
            StBusy: if (pcpi_ready_i || unclaimed_last) state_d = StResp;
            StResp: if (rsp_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from state only
    always_comb begin
        cmd_ready_o  = (state_q == StIdle);
        pcpi_valid_o = (state_q == StBusy);
        rsp_valid_o  = (state_q == StResp);
    end

    // Datapath next-state: operand capture, unclaimed counter, response capture
    always_comb begin
        cnt_d    = cnt_q;
        insn_d   = insn_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rsp_wr_d = rsp_wr_q;
        rsp_rd_d = rsp_rd_q;
        rsp_to_d = rsp_to_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    insn_d = cmd_insn_i;
                    rs1_d  = cmd_rs1_i;
                    rs2_d  = cmd_rs2_i;
                    cnt_d  = '0;
                end
            end
            StBusy: begin
                if (pcpi_ready_i) begin
                    rsp_wr_d = pcpi_wr_i;
                    rsp_rd_d = pcpi_wr_i ? pcpi_rd_i : 32'd0;
                    rsp_to_d = 1'b0;
                end else if (pcpi_wait_i) begin
                    cnt_d = '0;
                end else if (unclaimed_last) begin
                    rsp_wr_d = 1'b0;
                    rsp_rd_d = 32'd0;
                    rsp_to_d = 1'b1;
                end else begin
                    // Never reaches past CntLast, so no wrap is possible.
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q    <= '0;
            insn_q   <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rsp_wr_q <= 1'b0;
            rsp_rd_q <= '0;
            rsp_to_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            insn_q   <= insn_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rsp_wr_q <= rsp_wr_d;
            rsp_rd_q <= rsp_rd_d;
            rsp_to_q <= rsp_to_d;
        end
    end

    assign pcpi_insn_o   = insn_q;
    assign pcpi_rs1_o    = rs1_q;
    assign pcpi_rs2_o    = rs2_q;
    assign rsp_wr_o      = rsp_wr_q;
    assign rsp_rd_o      = rsp_rd_q;
    assign rsp_timeout_o = rsp_to_q;

endmodule
